// File: rtl/riscv_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, stage FSM states
// and the iteration count of the shift-add multiplier.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SRA  = 4'b1001,
      ALU_MUL  = 4'b1010
   } alu_op_t;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

   localparam int MUL_STEPS = 32;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier (low 32 bits of the product), one partial
// product per step; only built when EXECUTE_MUL_EN is defined.
`ifdef EXECUTE_MUL_EN
module mul_iter
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        step,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] product
);

   localparam int CNT_W = $clog2(MUL_STEPS);

   logic [31:0]      acc;
   logic [31:0]      mcand;
   logic [31:0]      mplier;
   logic [31:0]      acc_next;
   logic [CNT_W-1:0] count;

   assign acc_next = acc + (mplier[0] ? mcand : 32'd0);

   // The final step's sum is handed out combinationally so the stage can load it
   // on the same edge that completes the last iteration.
   assign done    = step && (count == CNT_W'(MUL_STEPS - 1));
   assign product = acc_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         count  <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: inline ALU with a one-entry output register; MUL goes through
// the iterative multiplier when EXECUTE_MUL_EN is defined.
module execute_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   input  logic [31:0] imm,
   input  logic        alu_src,
   input  logic [3:0]  alu_control,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        zero,
   output logic        busy,
   output logic        state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid && ready; a
   // producer holds valid and its payload steady until that edge.

   state_t      state, state_next;
   logic        accept;
   logic        is_mul;
   logic        mul_done;
   logic [31:0] mul_product;
   logic [31:0] op_b;
   logic [31:0] alu_result;
   logic [4:0]  pend_rd;
   logic        pend_reg_write;

   assign op_b   = alu_src ? imm : rd2;
   assign accept = in_valid && in_ready;

   always_comb begin
      alu_result = '0;
      case (alu_control)
         ALU_AND:  alu_result = rd1 & op_b;
         ALU_OR:   alu_result = rd1 | op_b;
         ALU_ADD:  alu_result = rd1 + op_b;
         ALU_XOR:  alu_result = rd1 ^ op_b;
         ALU_SLL:  alu_result = rd1 << op_b[4:0];
         ALU_SRL:  alu_result = rd1 >> op_b[4:0];
         ALU_SUB:  alu_result = rd1 - op_b;
         ALU_SLT:  alu_result = {31'd0, $signed(rd1) < $signed(op_b)};
         ALU_SLTU: alu_result = {31'd0, rd1 < op_b};
         ALU_SRA:  alu_result = $unsigned($signed(rd1) >>> op_b[4:0]);
         default:  alu_result = '0;
      endcase
   end

`ifdef EXECUTE_MUL_EN
   assign is_mul = (alu_control == ALU_MUL);

   mul_iter u_mul_iter (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && is_mul),
      .step    (state == MUL_BUSY),
      .a       (rd1),
      .b       (op_b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Destination of the multiply in flight, released with its product.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_rd        <= '0;
         pend_reg_write <= 1'b0;
      end else if (accept && is_mul) begin
         pend_rd        <= rd;
         pend_reg_write <= reg_write;
      end
   end
`else
   assign is_mul         = 1'b0;
   assign mul_done       = 1'b0;
   assign mul_product    = '0;
   assign pend_rd        = '0;
   assign pend_reg_write = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
         MUL_BUSY: if (mul_done)         state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_comb begin
`ifdef EXECUTE_MUL_EN
      busy = (state == MUL_BUSY);
`else
      busy = 1'b0;
`endif
      in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
      state_dbg = state;
   end

   // A load wins over a drain, so a completing result can replace one leaving.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         result        <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         zero          <= 1'b1;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (mul_done) begin
         out_valid     <= 1'b1;
         result        <= mul_product;
         out_rd        <= pend_rd;
         out_reg_write <= pend_reg_write;
         zero          <= (mul_product == 32'd0);
      end else if (accept && !is_mul) begin
         out_valid     <= 1'b1;
         result        <= alu_result;
         out_rd        <= rd;
         out_reg_write <= reg_write;
         zero          <= (alu_result == 32'd0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus random
// traffic scored against a reference model; honours EXECUTE_MUL_EN.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] rd1, rd2, imm;
   logic        alu_src;
   logic [3:0]  alu_control;
   logic [4:0]  rd;
   logic        reg_write;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        zero;
   logic        busy;
   logic        state_dbg;

   int total = 0;
   int bad   = 0;
   logic [37:0] exp_q[$];
   logic        rand_ready = 1'b0;

`ifdef EXECUTE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   execute_stage dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rd1           (rd1),
      .rd2           (rd2),
      .imm           (imm),
      .alu_src       (alu_src),
      .alu_control   (alu_control),
      .rd            (rd),
      .reg_write     (reg_write),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .out_rd        (out_rd),
      .out_reg_write (out_reg_write),
      .zero          (zero),
      .busy          (busy),
      .state_dbg     (state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
      logic [63:0] wide;
      logic [31:0] fill;
      int          sh;
      sh = int'(b % 32);
      case (op)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return a + b;
         4'd3:  return a ^ b;
         4'd4:  return a << sh;
         4'd5:  return a >> sh;
         4'd6:  return a - b;
         4'd7:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd8:  return (a < b) ? 32'd1 : 32'd0;
         4'd9:  begin
            fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
            return (a >> sh) | fill;
         end
         4'd10: begin
            if (!MUL_EN) return 32'd0;
            wide = {32'd0, a} * {32'd0, b};
            return wide[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] im,
                        input logic s, input logic [3:0] op, input logic [4:0] d,
                        input logic w, output int waits);
      bit ok;
      rd1 = a; rd2 = b2; imm = im; alu_src = s; alu_control = op; rd = d; reg_write = w;
      in_valid = 1'b1;
      waits = 0;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back({w, d, ref_alu(a, s ? im : b2, op)});
            ok = 1'b1;
            break;
         end
         waits++;
         @(posedge clk); #1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout: actual=no_accept required=accept");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic        held_v = 1'b0;
   logic        held_flush = 1'b0;
   logic [31:0] held_res;
   logic [4:0]  held_rd;

   always @(negedge clk) begin
      logic [37:0] e;
      if (!reset) begin
         held_v = 1'b0;
      end else begin
         if (held_v && !held_flush) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, held_res);
            check("hold_rd", 32'(out_rd), 32'(held_rd));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out: actual=%h required=none", result);
            end else begin
               e = exp_q.pop_front();
               check("sb_result", result, e[31:0]);
               check("sb_rd", 32'(out_rd), 32'(e[36:32]));
               check("sb_reg_write", 32'(out_reg_write), 32'(e[37]));
               check("sb_zero", 32'(zero), 32'(e[31:0] == 32'd0));
            end
         end
         held_v     = out_valid && !out_ready;
         held_flush = flush;
         held_res   = result;
         held_rd    = out_rd;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int w, n, busy_cnt, stale;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      rd1 = '0; rd2 = '0; imm = '0; alu_src = 1'b0; alu_control = '0; rd = '0; reg_write = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_reg_write", 32'(out_reg_write), 32'd0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      // ADD, latency 1
      issue(32'd5, 32'd7, 32'd0, 1'b0, 4'b0010, 5'd3, 1'b1, w);
      @(negedge clk);
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_result", result, 32'd12);
      check("add_rd", 32'(out_rd), 32'd3);
      check("add_zero", 32'(zero), 32'd0);
      @(posedge clk); #1;

      // SUB with immediate giving zero
      issue(32'd9, 32'd1234, 32'd9, 1'b1, 4'b0110, 5'd4, 1'b1, w);
      @(negedge clk);
      check("sub_result", result, 32'd0);
      check("sub_zero", 32'(zero), 32'd1);
      @(posedge clk); #1;

      // SRA sign fill
      issue(32'h8000_0000, 32'd4, 32'd0, 1'b0, 4'b1001, 5'd5, 1'b1, w);
      @(negedge clk);
      check("sra_result", result, 32'hF800_0000);
      @(posedge clk); #1;

      // Backpressure then back-to-back transfer + accept
      out_ready = 1'b0;
      issue(32'd5, 32'd7, 32'd0, 1'b0, 4'b0010, 5'd3, 1'b1, w);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_result", result, 32'd12);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      issue(32'h0F0F_0000, 32'h00FF_00FF, 32'd0, 1'b0, 4'b0011, 5'd9, 1'b0, w);
      check("b2b_waits", 32'(w), 32'd0);
      @(negedge clk);
      check("b2b_result", result, 32'h0FF0_00FF);
      check("b2b_reg_write", 32'(out_reg_write), 32'd0);
      @(posedge clk); #1;

      // MUL latency and busy window
      issue(32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 4'b1010, 5'd7, 1'b1, w);
      busy_cnt = 0;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         n = k;
         if (out_valid) break;
         if (busy) busy_cnt++;
      end
      check("mul_latency", 32'(n), MUL_EN ? 32'd33 : 32'd1);
      check("mul_busy_cycles", 32'(busy_cnt), MUL_EN ? 32'd32 : 32'd0);
      check("mul_result", result, MUL_EN ? 32'hFFFF_FFFD : 32'd0);
      @(posedge clk); #1;

      // Flush in busy cycle 10 of a multiply
      issue(32'd1234, 32'd5678, 32'd0, 1'b0, 4'b1010, 5'd8, 1'b1, w);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      exp_q.delete();
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_in_ready_after", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Reset in the middle of a multiply
      issue(32'd77, 32'd99, 32'd0, 1'b0, 4'b1010, 5'd10, 1'b1, w);
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      exp_q.delete();
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_result", result, 32'd0);
      check("mrst_rd", 32'(out_rd), 32'd0);
      check("mrst_reg_write", 32'(out_reg_write), 32'd0);
      check("mrst_zero", 32'(zero), 32'd1);
      check("mrst_busy", 32'(busy), 32'd0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      stale = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) stale++;
      end
      check("mrst_no_stale", 32'(stale), 32'd0);
      @(posedge clk); #1;

      // Random traffic under random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b2;
         a  = $urandom();
         b2 = ($urandom_range(0, 3) == 0) ? a : $urandom();
         if ($urandom_range(0, 7) == 0) b2 = 32'($urandom_range(0, 40));
         issue(a, b2, $urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), w);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk); #2 out_ready = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      @(negedge clk);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have one clock and one asynchronous active-low reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-low (0 = reset).
REQ-002 SHALL accept from decode: in_valid input 1, operation offered; in_ready output 1, stage can accept; rd1 input 32, operand A; rd2 input 32, register operand B; imm input 32, immediate operand B; alu_src input 1, 1 selects imm as B; alu_control input 4, operation code; rd input 5, destination register; reg_write input 1, write-back enable.
REQ-003 SHALL present to write-back: out_valid output 1, result held; out_ready input 1, consumer takes result; result output 32; out_rd output 5; out_reg_write output 1; zero output 1, result == 0.
REQ-004 SHALL have: flush input 1, discard in-flight work; busy output 1, multi-cycle operation in progress.

Function
REQ-005 SHALL perform a transfer in when in_valid && in_ready at a rising clk edge, and a transfer out when out_valid && out_ready.
REQ-006 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
REQ-007 SHALL use B = alu_src ? imm : rd2.
REQ-008 SHALL decode alu_control: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SRA, 1010 MUL (low 32 bits); any other code yields result 0.
REQ-009 SHALL use B[4:0] as shift amount; ADD/SUB/MUL wrap modulo 2^32; SLT/SLTU produce 0 or 1.
REQ-010 SHALL register single-cycle results: out_valid, result, out_rd, out_reg_write, zero update at the edge after acceptance (latency 1).
REQ-011 SHALL hold result, out_rd, out_reg_write, zero and out_valid stable while out_valid && !out_ready.
REQ-012 SHALL clear out_valid after a transfer out unless a new result is loaded at the same edge (back-to-back throughput 1 per cycle).
REQ-013 SHALL implement FSM states IDLE and MUL_BUSY: IDLE->MUL_BUSY on accepting MUL; MUL_BUSY iterates one shift-add step per cycle for 32 cycles; after step 32 loads output register and returns to IDLE (latency 33 from acceptance).
REQ-014 SHALL assert busy exactly while state == MUL_BUSY.
REQ-015 SHALL, on flush, clear out_valid and force state to IDLE at the next edge, aborting any multiply; flush takes priority over acceptance and result load.
REQ-016 SHALL, on simultaneous transfer out and multiply completion, load the multiply result and keep out_valid = 1.

Reset
REQ-017 SHALL, while reset = 0, asynchronously set state IDLE, out_valid 0, result 0, out_rd 0, out_reg_write 0, zero 1, busy 0, iteration counter 0, multiplier accumulator 0.
REQ-018 SHALL abort any multiply in progress on reset assertion and accept no operation until the first edge after reset = 1.

Configuration
REQ-019 SHALL compile the multiplier only when macro EXECUTE_MUL_EN is defined.
REQ-020 SHALL, without EXECUTE_MUL_EN, treat code 1010 as unknown (result 0, latency 1), never enter MUL_BUSY, and tie busy to 0.

Structure
REQ-021 SHALL take alu_control encodings (typedef enum, 4 bits), state enum and constant MUL_STEPS = 32 from shared package riscv_pkg.
REQ-022 SHALL place the iterative shift-add multiplier in sub-module mul_iter (start, operands, done, product); the ALU stays inline.

Verification
REQ-023 ADD: rd1=5, rd2=7, alu_src=0, code 0010, rd=3, out_ready=1 -> next cycle out_valid=1, result=12, out_rd=3, zero=0.
REQ-024 SUB/immediate: rd1=9, imm=9, alu_src=1, code 0110 -> result=0, zero=1; SRA rd1=0x80000000, rd2=4 -> 0xF8000000.
REQ-025 Backpressure: out_ready=0 after result 12 -> in_ready=0, result stays 12 for 5 cycles; out_ready=1 -> transfer, new op accepted same edge.
REQ-026 MUL (EXECUTE_MUL_EN): rd1=0xFFFFFFFF, rd2=3 -> busy=1 for 32 cycles, out_valid=1 at cycle 33, result=0xFFFFFFFD; without macro -> result 0 after 1 cycle.
REQ-027 Flush at cycle 10 of a multiply -> busy=0 and out_valid=0 next cycle, in_ready=1 the cycle after.
REQ-028 Reset asserted mid-multiply -> all outputs at REQ-017 values immediately, no stale out_valid after release.
